scan_chain_sequencer: RTL
=========================

// Module: scan_chain_sequencer
// PURPOSE
//  Drives one scan chain through a full load/capture/unload test cycle.
//  Generates TM and SI for the chain's scan cells and collects the chain's SO.
//  Compares the unloaded response against an expected vector and keeps pass/fail counts.
//  Sits upstream of the scan-inserted logic (feeds TM/SI) and downstream of its SO.
// PARAMETERS
//  CHAIN_LEN  2   number of scan cells in the chain (>=1)
//  CNT_W      8   width of pattern and fail counters
// PORTS
//  clk          in   1          rising-edge clock, shared with the scan cells
//  reset        in   1          synchronous, active-low reset
//  start        in   1          request one test pattern; accepted only in IDLE
//  pattern_in   in   CHAIN_LEN  stimulus; bit 0 shifted first (ends in last cell)
//  expected_in  in   CHAIN_LEN  expected response, same bit ordering as response
//  so_in        in   1          SO of the chain (Q of last scan cell)
//  tm           out  1          scan-mode select to the cells (1 = shift, 0 = capture)
//  si           out  1          serial data into the first cell
//  busy         out  1          high in every state except IDLE
//  done         out  1          one-cycle pulse when a pattern completes
//  pass         out  1          result of last pattern; valid from done onward
//  response     out  CHAIN_LEN  last unloaded response; bit 0 = first SO bit seen
//  pat_cnt      out  CNT_W      patterns completed, saturating
//  fail_cnt     out  CNT_W      patterns with mismatch, saturating
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): state=IDLE, tm=0, si=0, busy=0, done=0,
//   pass=0, response=0, pat_cnt=0, fail_cnt=0. Takes priority over everything,
//   including mid-operation; any partial pattern is discarded, counters cleared.
//  FSM: IDLE -> SHIFT_IN -> CAPTURE -> SHIFT_OUT -> DONE -> IDLE.
//  IDLE: tm=0, si=0. On start==1: latch pattern_in/expected_in, bit index=0,
//   go SHIFT_IN. start while not IDLE is ignored (no queuing).
//  SHIFT_IN: exactly CHAIN_LEN cycles; tm=1; in cycle k si=pattern[k].
//   After the CHAIN_LEN-th edge, pattern[0] sits in the last cell.
//  CAPTURE: exactly 1 cycle; tm=0, si=0; cells load functional data at its edge.
//  SHIFT_OUT: exactly CHAIN_LEN cycles; tm=1, si=0.
//   At the edge ending cycle k, response[k] <= so_in (k=0 is last cell's capture).
//  DONE: 1 cycle; done=1; pass=(response==expected) registered at the
//   DONE-entry edge so pass/response are stable while done=1 and held until the
//   next DONE. pat_cnt+=1 and fail_cnt+=(!pass) at the same edge; both
//   saturate at 2^CNT_W-1 (no wrap).
//  tm/si/done/busy are registered outputs (state-decoded from flops, glitch-free).
//  Latency: start accepted at edge E0 -> done high in cycle 2*CHAIN_LEN+2
//   after E0; back in IDLE (busy=0) one cycle later; next start accepted then.
//  start held high continuously: a new pattern begins each time IDLE is reached.
//  CHAIN_LEN=1: SHIFT_IN and SHIFT_OUT each last one cycle; no special casing.
// TESTING (CHAIN_LEN=2, chain = 2-cell scan-inserted OR/AND/NOT logic, A=1)
//  1 reset low 3 cycles mid-SHIFT_IN -> tm=0, busy=0, counters 0, state IDLE.
//  2 start, pattern=2'b10 (qB=1,qC=0), expected=2'b10 -> tm=1,1,0,1,1;
//    si=0,1 in shift-in; response=2'b10, pass=1, done 6 cycles after start.
//  3 start, pattern=2'b00, expected=2'b01 -> response=2'b01, pass=1, pat_cnt=2.
//  4 start, pattern=2'b00, expected=2'b11 -> pass=0, fail_cnt=1.
//  5 start pulsed while busy -> ignored; exactly one done per accepted start.
//  6 CNT_W=2, 5 failing patterns -> pat_cnt=fail_cnt=3 (saturated).

Source files
------------

// File: rtl/scan_chain_sequencer.sv
// Scan-chain test sequencer: shifts a pattern in, pulses one capture cycle,
// shifts the response out, then compares it and updates pass/fail counters.
module scan_chain_sequencer #(
  parameter int CHAIN_LEN = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expected_in,
  input  logic                 so_in,
  output logic                 tm,
  output logic                 si,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response,
  output logic [CNT_W-1:0]     pat_cnt,
  output logic [CNT_W-1:0]     fail_cnt
);

  localparam int IDX_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] cap_q;
  logic [CHAIN_LEN-1:0] response_q;
  logic [CHAIN_LEN-1:0] resp_d;
  logic                 pass_d;
  logic                 tm_q, si_q, busy_q, done_q, pass_q;
  logic [CNT_W-1:0]     pat_cnt_q, fail_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Response as it will look once the SO bit of the current cycle is folded in.
  always_comb begin
    resp_d        = cap_q;
    resp_d[idx_q] = so_in;
    pass_d        = (resp_d == exp_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tm_q       <= 1'b0;
      si_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      response_q <= '0;
      pat_cnt_q  <= '0;
      fail_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pat_q   <= pattern_in >> 1;
            exp_q   <= expected_in;
            si_q    <= pattern_in[0];
            tm_q    <= 1'b1;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (idx_q == LAST_IDX) begin
            tm_q    <= 1'b0;
            si_q    <= 1'b0;
            idx_q   <= '0;
            state_q <= CAPTURE;
          end else begin
            si_q  <= pat_q[0];
            pat_q <= pat_q >> 1;
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        CAPTURE: begin
          tm_q    <= 1'b1;
          state_q <= SHIFT_OUT;
        end
        SHIFT_OUT: begin
          cap_q <= resp_d;
          if (idx_q == LAST_IDX) begin
            tm_q       <= 1'b0;
            done_q     <= 1'b1;
            response_q <= resp_d;
            pass_q     <= pass_d;
            pat_cnt_q  <= sat_inc(pat_cnt_q, 1'b1);
            fail_cnt_q <= sat_inc(fail_cnt_q, !pass_d);
            idx_q      <= '0;
            state_q    <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tm       = tm_q;
  assign si       = si_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign response = response_q;
  assign pat_cnt  = pat_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule
